prl_tx_fsm: RTL and testbench
=============================

// Module: prl_tx_fsm
// PURPOSE
//  USB-PD Protocol Layer transmit state machine (PRL_Tx).
//  - Takes a message request from the Policy Engine and stamps the MessageID into the header.
//  - Starts the PHY and waits for the matching GoodCRC, which the PRL_Rx block reports.
//  - Retries up to N_RETRY times, then reports Sent, Transmission Error or Discarded back to the PE.
//  - Sits between the PE, the PHY transmitter and the PRL_Rx block.
// PARAMETERS
//  N_RETRY      2     retransmissions after the first attempt (nRetryCount)
//  CRC_TIMEOUT  1000  CRCReceiveTimer length in CLK cycles, >=2
//  TIMER_W      16    timer width; must satisfy 2**TIMER_W > CRC_TIMEOUT
// PORTS
//  CLK              in   1   clock, all logic on posedge
//  reset            in   1   synchronous, active-high
//  pe_tx_req        in   1   PE transmit request; sampled only in WAIT_REQ
//  pe_tx_header     in   16  PE header; bits [11:9] replaced by MessageID
//  prl_layer_reset  in   1   soft/protocol reset: abort and clear MessageIDCounter
//  phy_tx_done      in   1   PHY finished sending (1-cycle pulse)
//  phy_tx_fail      in   1   PHY could not send, bus busy/collision (pulse)
//  rx_msg_rcvd      in   1   PRL_Rx received a non-GoodCRC message (pulse)
//  rx_goodcrc       in   1   PRL_Rx received a GoodCRC (pulse)
//  rx_goodcrc_id    in   3   MessageID of that GoodCRC
//  phy_tx_start     out  1   1-cycle start strobe to the PHY
//  phy_tx_header    out  16  latched header with MessageID, stable while busy
//  pe_tx_sent       out  1   1-cycle: message acknowledged
//  pe_tx_error      out  1   1-cycle: retries exhausted or PHY failure
//  pe_tx_discarded  out  1   1-cycle: aborted by an incoming message
//  tx_busy          out  1   high whenever state != WAIT_REQ
//  msg_id           out  3   current MessageIDCounter
// BEHAVIOUR
//  Reset values
//  - state = WAIT_REQ.
//  - msg_id, retry count and timer = 0; phy_tx_header = 0.
//  - All strobes = 0 and tx_busy = 0.
//  Outputs
//  - All strobes are Moore outputs, decoded from the registered state.
//  States: WAIT_REQ, LAYER_RST, CONSTRUCT, WAIT_PHY, WAIT_CRC, MATCH_ID, CHECK_RETRY,
//          SENT, TX_ERROR, DISCARD.
//  Global priority
//  - prl_layer_reset high in any state -> LAYER_RST next cycle.
//  - No status strobe is issued on that abort.
//  - LAYER_RST sets msg_id = 0 and retry = 0, then goes to WAIT_REQ (1 cycle).
//  WAIT_REQ
//  - On pe_tx_req: latch header with [11:9] = msg_id, retry = 0, go to CONSTRUCT.
//  - pe_tx_req is ignored in every other state.
//  CONSTRUCT
//  - phy_tx_start = 1 for this cycle only; timer = 0; go to WAIT_PHY.
//  - Latency: request at cycle N gives phy_tx_start at cycle N+1.
//  WAIT_PHY, priority order
//  - rx_msg_rcvd -> DISCARD.
//  - phy_tx_fail -> TX_ERROR.
//  - phy_tx_done -> WAIT_CRC (timer = 0).
//  - Otherwise stay; there is no timeout here.
//  WAIT_CRC
//  - timer increments every cycle.
//  - Priority: rx_goodcrc -> MATCH_ID (capture id); then rx_msg_rcvd -> DISCARD;
//    then timer == CRC_TIMEOUT-1 -> CHECK_RETRY.
//  MATCH_ID
//  - captured id == msg_id -> SENT; otherwise -> CHECK_RETRY.
//  CHECK_RETRY
//  - retry == N_RETRY -> TX_ERROR.
//  - Otherwise retry++ and go to CONSTRUCT; the same header and MessageID are resent.
//  SENT / TX_ERROR / DISCARD
//  - Matching strobe = 1 for 1 cycle.
//  - msg_id = msg_id + 1, modulo 8 (7 wraps to 0); then go to WAIT_REQ.
//  - At most one of the three strobes is high in any cycle.
//  Other rules
//  - A pe_tx_req pulse present in the same cycle the block returns to WAIT_REQ is not
//    seen; the PE must wait for tx_busy = 0.
//  - reset has priority over every input, including prl_layer_reset.
// TESTING
//  1 Basic send: req with header 16'h0041; matching GoodCRC id 0 three cycles after phy_tx_done
//    -> phy_tx_header = 16'h0041, pe_tx_sent pulse, msg_id = 1.
//  2 Timeout: no GoodCRC -> 3 phy_tx_start strobes spaced CRC_TIMEOUT+3 cycles apart,
//    then pe_tx_error, msg_id = 1.
//  3 Wrong ID: GoodCRC id 5 while msg_id = 0 -> retry; next GoodCRC id 0 -> pe_tx_sent.
//  4 Discard: rx_msg_rcvd in WAIT_CRC -> pe_tx_discarded, no further phy_tx_start.
//  5 Wrap and reset: 8 successful sends -> msg_id wraps to 0; then prl_layer_reset in WAIT_CRC
//    with msg_id = 3 -> no strobe, msg_id = 0, tx_busy = 0 two cycles later.
//  6 Collision: phy_tx_fail in WAIT_PHY -> pe_tx_error, no retry, msg_id incremented.

Source files
------------

// File: rtl/prl_tx_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : prl_tx_fsm                                                        |
// | Purpose  : USB-PD Protocol Layer transmit state machine (PRL_Tx). Accepts a  |
// |            message from the Policy Engine, stamps the MessageID into header  |
// |            bits [11:9], starts the PHY, waits for a matching GoodCRC from    |
// |            PRL_Rx, retries up to N_RETRY times and reports Sent, Error or    |
// |            Discarded back to the PE.                                         |
// | Ports    : CLK, reset (sync, active-high)                                    |
// |            PE side  : pe_tx_req, pe_tx_header[15:0], pe_tx_sent,             |
// |                       pe_tx_error, pe_tx_discarded                           |
// |            PHY side : phy_tx_start, phy_tx_header[15:0], phy_tx_done,        |
// |                       phy_tx_fail                                            |
// |            PRL_Rx   : rx_msg_rcvd, rx_goodcrc, rx_goodcrc_id[2:0]            |
// |            Control  : prl_layer_reset; status tx_busy, msg_id[2:0]           |
// | Revision : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module prl_tx_fsm #(
  parameter int N_RETRY     = 2,
  parameter int CRC_TIMEOUT = 1000,
  parameter int TIMER_W     = 16
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        pe_tx_req,
  input  logic [15:0] pe_tx_header,
  input  logic        prl_layer_reset,
  input  logic        phy_tx_done,
  input  logic        phy_tx_fail,
  input  logic        rx_msg_rcvd,
  input  logic        rx_goodcrc,
  input  logic [2:0]  rx_goodcrc_id,
  output logic        phy_tx_start,
  output logic [15:0] phy_tx_header,
  output logic        pe_tx_sent,
  output logic        pe_tx_error,
  output logic        pe_tx_discarded,
  output logic        tx_busy,
  output logic [2:0]  msg_id
);

  // Retry counter must hold 0..N_RETRY inclusive.
  localparam int c_RETRY_W = (N_RETRY < 1) ? 1 : $clog2(N_RETRY + 1);

  typedef enum logic [3:0] {
    WAIT_REQ    = 4'd0,
    LAYER_RST   = 4'd1,
    CONSTRUCT   = 4'd2,
    WAIT_PHY    = 4'd3,
    WAIT_CRC    = 4'd4,
    MATCH_ID    = 4'd5,
    CHECK_RETRY = 4'd6,
    SENT        = 4'd7,
    TX_ERROR    = 4'd8,
    DISCARD     = 4'd9
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [2:0]             r_msg_id;
  logic [c_RETRY_W-1:0]   r_retry;
  logic [TIMER_W-1:0]     r_timer;
  logic [15:0]            r_hdr;
  logic [2:0]             r_crc_id;
  logic [15:0]            w_hdr_stamped;
  logic                   w_retry_done;
  logic                   w_timeout;

  assign w_retry_done = (r_retry == c_RETRY_W'(N_RETRY));
  assign w_timeout    = (r_timer == TIMER_W'(CRC_TIMEOUT - 1));

  // Incoming header with the current MessageID spliced into [11:9].
  always_comb begin
    w_hdr_stamped       = pe_tx_header;
    w_hdr_stamped[11:9] = r_msg_id;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= WAIT_REQ;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    w_next          = r_state;
    phy_tx_start    = 1'b0;
    pe_tx_sent      = 1'b0;
    pe_tx_error     = 1'b0;
    pe_tx_discarded = 1'b0;
    tx_busy         = (r_state != WAIT_REQ);

    case (r_state)
      WAIT_REQ:    if (pe_tx_req) w_next = CONSTRUCT;
      LAYER_RST:   w_next = WAIT_REQ;
      CONSTRUCT: begin
        phy_tx_start = 1'b1;
        w_next       = WAIT_PHY;
      end
      WAIT_PHY: begin
        if (rx_msg_rcvd)      w_next = DISCARD;
        else if (phy_tx_fail) w_next = TX_ERROR;
        else if (phy_tx_done) w_next = WAIT_CRC;
      end
      WAIT_CRC: begin
        if (rx_goodcrc)       w_next = MATCH_ID;
        else if (rx_msg_rcvd) w_next = DISCARD;
        else if (w_timeout)   w_next = CHECK_RETRY;
      end
      MATCH_ID:    w_next = (r_crc_id == r_msg_id) ? SENT : CHECK_RETRY;
      CHECK_RETRY: w_next = w_retry_done ? TX_ERROR : CONSTRUCT;
      SENT: begin
        pe_tx_sent = 1'b1;
        w_next     = WAIT_REQ;
      end
      TX_ERROR: begin
        pe_tx_error = 1'b1;
        w_next      = WAIT_REQ;
      end
      DISCARD: begin
        pe_tx_discarded = 1'b1;
        w_next          = WAIT_REQ;
      end
      default:     w_next = WAIT_REQ;
    endcase

    // Protocol-layer reset overrides every transition and suppresses status.
    if (prl_layer_reset) w_next = LAYER_RST;
  end

  // Datapath: MessageID, retry count, CRC timer, header and GoodCRC id.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_msg_id <= 3'd0;
      r_retry  <= '0;
      r_timer  <= '0;
      r_hdr    <= 16'd0;
      r_crc_id <= 3'd0;
    end else if (r_state == LAYER_RST) begin
      r_msg_id <= 3'd0;
      r_retry  <= '0;
    end else if (!prl_layer_reset) begin
      case (r_state)
        WAIT_REQ: begin
          if (pe_tx_req) begin
            r_hdr   <= w_hdr_stamped;
            r_retry <= '0;
          end
        end
        CONSTRUCT: r_timer <= '0;
        WAIT_PHY: begin
          if (!rx_msg_rcvd && !phy_tx_fail && phy_tx_done) r_timer <= '0;
        end
        WAIT_CRC: begin
          r_timer <= r_timer + TIMER_W'(1);
          if (rx_goodcrc) r_crc_id <= rx_goodcrc_id;
        end
        CHECK_RETRY: begin
          if (!w_retry_done) r_retry <= r_retry + c_RETRY_W'(1);
        end
        // 3-bit counter wraps 7 -> 0 naturally.
        SENT, TX_ERROR, DISCARD: r_msg_id <= r_msg_id + 3'd1;
        default: ;
      endcase
    end
  end

  assign phy_tx_header = r_hdr;
  assign msg_id        = r_msg_id;

endmodule
`default_nettype wire

// File: tb/tb_prl_tx_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_prl_tx_fsm                                                     |
// | Purpose  : Self-checking bench for prl_tx_fsm: directed protocol scenarios   |
// |            followed by randomized traffic, all outputs compared each cycle   |
// |            against a transaction-level reference model.                      |
// | Revision : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_prl_tx_fsm;

  localparam int N_RETRY     = 2;
  localparam int CRC_TIMEOUT = 8;
  localparam int TIMER_W     = 4;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        pe_tx_req = 1'b0;
  logic [15:0] pe_tx_header = 16'd0;
  logic        prl_layer_reset = 1'b0;
  logic        phy_tx_done = 1'b0;
  logic        phy_tx_fail = 1'b0;
  logic        rx_msg_rcvd = 1'b0;
  logic        rx_goodcrc = 1'b0;
  logic [2:0]  rx_goodcrc_id = 3'd0;
  logic        phy_tx_start;
  logic [15:0] phy_tx_header;
  logic        pe_tx_sent;
  logic        pe_tx_error;
  logic        pe_tx_discarded;
  logic        tx_busy;
  logic [2:0]  msg_id;

  prl_tx_fsm #(
    .N_RETRY    (N_RETRY),
    .CRC_TIMEOUT(CRC_TIMEOUT),
    .TIMER_W    (TIMER_W)
  ) dut (
    .CLK            (CLK),
    .reset          (reset),
    .pe_tx_req      (pe_tx_req),
    .pe_tx_header   (pe_tx_header),
    .prl_layer_reset(prl_layer_reset),
    .phy_tx_done    (phy_tx_done),
    .phy_tx_fail    (phy_tx_fail),
    .rx_msg_rcvd    (rx_msg_rcvd),
    .rx_goodcrc     (rx_goodcrc),
    .rx_goodcrc_id  (rx_goodcrc_id),
    .phy_tx_start   (phy_tx_start),
    .phy_tx_header  (phy_tx_header),
    .pe_tx_sent     (pe_tx_sent),
    .pe_tx_error    (pe_tx_error),
    .pe_tx_discarded(pe_tx_discarded),
    .tx_busy        (tx_busy),
    .msg_id         (msg_id)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;

  // Event counters observed from the DUT (used only for relative counts).
  int n_start = 0, n_sent = 0, n_err = 0, n_disc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks what the transmitter is doing in terms of the
  // protocol (idle, building, awaiting PHY, awaiting CRC with a deadline, ...).
  // ---------------------------------------------------------------------------
  localparam int P_IDLE = 0, P_LRST = 1, P_BUILD = 2, P_PHY = 3, P_CRC = 4,
                 P_MATCH = 5, P_RETRY = 6, P_OK = 7, P_ERR = 8, P_DISC = 9;

  int          ph = P_IDLE;
  bit          m_valid = 0;
  int          m_id = 0;
  int          m_tries = 0;
  int          m_cid = 0;
  logic [15:0] m_hdr = 16'd0;
  int          mcyc = 0;
  int          deadline = 0;

  always @(posedge CLK) begin
    mcyc++;
    if (reset) begin
      ph = P_IDLE; m_id = 0; m_tries = 0; m_hdr = 16'd0; m_valid = 1;
    end else if (m_valid) begin
      if (ph == P_LRST) begin
        m_id = 0; m_tries = 0;
      end
      if (prl_layer_reset) begin
        ph = P_LRST;
      end else begin
        case (ph)
          P_IDLE: if (pe_tx_req) begin
            m_hdr = {pe_tx_header[15:12], 3'(m_id), pe_tx_header[8:0]};
            m_tries = 0;
            ph = P_BUILD;
          end
          P_LRST:  ph = P_IDLE;
          P_BUILD: ph = P_PHY;
          P_PHY: begin
            if (rx_msg_rcvd)      ph = P_DISC;
            else if (phy_tx_fail) ph = P_ERR;
            else if (phy_tx_done) begin
              ph = P_CRC;
              deadline = mcyc + CRC_TIMEOUT;
            end
          end
          P_CRC: begin
            if (rx_goodcrc) begin
              m_cid = int'(rx_goodcrc_id);
              ph = P_MATCH;
            end else if (rx_msg_rcvd)  ph = P_DISC;
            else if (mcyc == deadline) ph = P_RETRY;
          end
          P_MATCH: ph = (m_cid == m_id) ? P_OK : P_RETRY;
          P_RETRY: begin
            if (m_tries == N_RETRY) ph = P_ERR;
            else begin
              m_tries++;
              ph = P_BUILD;
            end
          end
          default: begin
            m_id = (m_id + 1) % 8;
            ph = P_IDLE;
          end
        endcase
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    logic [23:0] act, exp;
    if (phy_tx_start === 1'b1)    n_start++;
    if (pe_tx_sent === 1'b1)      n_sent++;
    if (pe_tx_error === 1'b1)     n_err++;
    if (pe_tx_discarded === 1'b1) n_disc++;
    if (m_valid) begin
      act = {phy_tx_start, pe_tx_sent, pe_tx_error, pe_tx_discarded, tx_busy, msg_id, phy_tx_header};
      exp = {ph == P_BUILD, ph == P_OK, ph == P_ERR, ph == P_DISC, ph != P_IDLE, 3'(m_id), m_hdr};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL cycle_compare: got %06h expected %06h (t=%0t)", act, exp, $time);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge CLK);
    #1;
    ncyc++;
    pe_tx_req = 1'b0; phy_tx_done = 1'b0; phy_tx_fail = 1'b0;
    rx_msg_rcvd = 1'b0; rx_goodcrc = 1'b0; prl_layer_reset = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic logic outsel(input int sel);
    case (sel)
      0:       return phy_tx_start;
      1:       return pe_tx_sent;
      2:       return pe_tx_error;
      default: return pe_tx_discarded;
    endcase
  endfunction

  task automatic wait_for(input string name, input int sel, input int maxc);
    bit seen = 0;
    for (int i = 0; i < maxc; i++) begin
      if (outsel(sel) === 1'b1) begin
        seen = 1;
        break;
      end
      step();
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic send_ok(input logic [2:0] id);
    pe_tx_header = 16'($urandom);
    pe_tx_req = 1'b1;
    step();
    step();
    phy_tx_done = 1'b1;
    step();
    rx_goodcrc = 1'b1;
    rx_goodcrc_id = id;
    step();
    wait_for("send_ok_sent", 1, 5);
    step();
  endtask

  int t[3];
  int b_start, b_sent, b_err, b_disc;

  initial begin
    reset = 1'b1;
    step();
    step();
    // Reset state
    chk("reset_busy", 32'(tx_busy), 32'd0);
    chk("reset_msg_id", 32'(msg_id), 32'd0);
    chk("reset_header", 32'(phy_tx_header), 32'd0);
    reset = 1'b0;

    // 1 Basic send
    reset_dut();
    pe_tx_header = 16'h0041;
    pe_tx_req = 1'b1;
    step();
    chk("start_latency", 32'(phy_tx_start), 32'd1);
    step();
    phy_tx_done = 1'b1;
    step();
    step();
    step();
    rx_goodcrc = 1'b1;
    rx_goodcrc_id = 3'd0;
    step();
    wait_for("basic_sent", 1, 5);
    chk("basic_header", 32'(phy_tx_header), 32'h0041);
    step();
    chk("basic_msg_id", 32'(msg_id), 32'd1);
    chk("basic_idle", 32'(tx_busy), 32'd0);

    // 2 Timeout with retries
    reset_dut();
    b_start = n_start; b_err = n_err;
    pe_tx_header = 16'h1234;
    pe_tx_req = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      wait_for("timeout_start", 0, CRC_TIMEOUT + 10);
      t[k] = ncyc;
      step();
      phy_tx_done = 1'b1;
      step();
    end
    wait_for("timeout_error", 2, CRC_TIMEOUT + 10);
    chk("timeout_header", 32'(phy_tx_header), 32'h1034);
    chk("retry_spacing1", 32'(t[1] - t[0]), 32'(CRC_TIMEOUT + 3));
    chk("retry_spacing2", 32'(t[2] - t[1]), 32'(CRC_TIMEOUT + 3));
    step();
    chk("timeout_msg_id", 32'(msg_id), 32'd1);
    for (int k = 0; k < 20; k++) step();
    chk("timeout_starts", 32'(n_start - b_start), 32'd3);
    chk("timeout_errors", 32'(n_err - b_err), 32'd1);

    // 3 Wrong GoodCRC id then correct one
    reset_dut();
    b_start = n_start;
    pe_tx_header = 16'hFFFF;
    pe_tx_req = 1'b1;
    step();
    step();
    phy_tx_done = 1'b1;
    step();
    rx_goodcrc = 1'b1;
    rx_goodcrc_id = 3'd5;
    step();
    wait_for("wrongid_retry", 0, 10);
    chk("wrongid_header", 32'(phy_tx_header), 32'hF1FF);
    step();
    phy_tx_done = 1'b1;
    step();
    rx_goodcrc = 1'b1;
    rx_goodcrc_id = 3'd0;
    step();
    wait_for("wrongid_sent", 1, 5);
    step();
    chk("wrongid_msg_id", 32'(msg_id), 32'd1);
    chk("wrongid_starts", 32'(n_start - b_start), 32'd2);

    // 4 Discard during CRC wait
    reset_dut();
    b_start = n_start;
    pe_tx_req = 1'b1;
    step();
    step();
    phy_tx_done = 1'b1;
    step();
    rx_msg_rcvd = 1'b1;
    step();
    wait_for("discard_strobe", 3, 5);
    for (int k = 0; k < 20; k++) step();
    chk("discard_starts", 32'(n_start - b_start), 32'd1);
    chk("discard_msg_id", 32'(msg_id), 32'd1);

    // 5 MessageID wrap and layer reset
    reset_dut();
    for (int k = 0; k < 8; k++) send_ok(3'(k));
    chk("wrap_msg_id", 32'(msg_id), 32'd0);
    for (int k = 0; k < 3; k++) send_ok(3'(k));
    chk("pre_lrst_msg_id", 32'(msg_id), 32'd3);
    pe_tx_req = 1'b1;
    step();
    step();
    phy_tx_done = 1'b1;
    step();
    step();
    b_sent = n_sent; b_err = n_err; b_disc = n_disc;
    prl_layer_reset = 1'b1;
    step();
    chk("lrst_busy1", 32'(tx_busy), 32'd1);
    step();
    chk("lrst_busy2", 32'(tx_busy), 32'd0);
    chk("lrst_msg_id", 32'(msg_id), 32'd0);
    step();
    chk("lrst_no_strobe", 32'((n_sent - b_sent) + (n_err - b_err) + (n_disc - b_disc)), 32'd0);

    // 6 PHY collision
    reset_dut();
    b_start = n_start;
    pe_tx_req = 1'b1;
    step();
    step();
    phy_tx_fail = 1'b1;
    step();
    wait_for("collision_error", 2, 5);
    for (int k = 0; k < 20; k++) step();
    chk("collision_starts", 32'(n_start - b_start), 32'd1);
    chk("collision_msg_id", 32'(msg_id), 32'd1);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int k = 0; k < 4000; k++) begin
      reset           = ($urandom_range(0, 599) == 0);
      pe_tx_req       = ($urandom_range(0, 9) < 3);
      pe_tx_header    = 16'($urandom);
      phy_tx_done     = ($urandom_range(0, 9) < 3);
      phy_tx_fail     = ($urandom_range(0, 49) == 0);
      rx_msg_rcvd     = ($urandom_range(0, 49) == 0);
      rx_goodcrc      = ($urandom_range(0, 9) < 2);
      rx_goodcrc_id   = $urandom_range(0, 1) ? 3'(m_id) : 3'($urandom);
      prl_layer_reset = ($urandom_range(0, 149) == 0);
      @(posedge CLK);
      #1;
      ncyc++;
    end
    reset = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
